// File: rtl/mux_sel_scanner_if.sv
// Bus between the scanner and its controller/mux: scan request, programming
// inputs, the mux select/sample pair and the frame result.
interface mux_sel_scanner_if #(
  parameter int unsigned DWELL_W = 4
);
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         mask;
  logic               mux_out;
  logic [1:0]         sel;
  logic               busy;
  logic [3:0]         frame;
  logic               frame_valid;

  modport master (
    output start, dwell, mask, mux_out,
    input  sel, busy, frame, frame_valid
  );

  modport slave (
    input  start, dwell, mask, mux_out,
    output sel, busy, frame, frame_valid
  );
endinterface

// File: rtl/mux_sel_scanner.sv
// Steps a 4:1 mux select through the enabled channels, dwells on each and
// packs the samples into a 4-bit frame. Optional macro SCAN_CONT_EN: free-running scans.
module mux_sel_scanner #(
  parameter int unsigned DWELL_W = 4
) (
  input logic              clk,
  input logic              rst,
  mux_sel_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         frame_q, frame_d;
  logic [3:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         nxt_ch;
  logic [2:0]         low_ch;

  // Lowest enabled channel at index >= lo; bit 2 flags that one exists.
  function automatic logic [2:0] first_from(input logic [3:0] m, input int unsigned lo);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= lo && m[i] && !r[2]) begin
        r = {1'b1, i[1:0]};
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    nxt_ch  = first_from(mask_q, {30'd0, sel_q} + 32'd1);
    low_ch  = first_from(bus.mask, 32'd0);

    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start && bus.mask != '0) begin
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          frame_d = '0;
          cnt_d   = '0;
          sel_d   = low_ch[1:0];
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == dwell_q) begin
          frame_d[sel_q] = bus.mux_out;
          cnt_d          = '0;
          if (nxt_ch[2]) begin
            sel_d = nxt_ch[1:0];
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      DONE: begin
`ifdef SCAN_CONT_EN
        // Re-latch from the live inputs; an all-zero new mask parks in IDLE
        // rather than scanning an empty channel set.
        if (mask_q != '0 && bus.mask != '0) begin
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          frame_d = '0;
          cnt_d   = '0;
          sel_d   = low_ch[1:0];
          state_d = SCAN;
        end else begin
          sel_d   = '0;
          state_d = IDLE;
        end
`else
        sel_d   = '0;
        state_d = IDLE;
`endif
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      frame_q <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame       = frame_q;
  assign bus.frame_valid = (state_q == DONE);

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner: a schedule-based model of the expected select /
// busy / pulse sequence plus directed scans with hand-computed results.
`timescale 1ns/1ps
module tb_mux_sel_scanner;
  localparam int unsigned DW = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] abcd = '0;

  mux_sel_scanner_if #(.DWELL_W(DW)) bus ();

  mux_sel_scanner #(.DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Downstream 4:1 mux: purely combinational from sel.
  assign bus.mux_out = abcd[bus.sel];

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;

  typedef struct {
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_frame   = '0;
  logic [3:0] m_pending = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle schedule: every enabled channel for dwell+1 cycles,
  // then one DONE cycle holding the last channel.
  function automatic void build(input logic [3:0] m, input logic [DW-1:0] d);
    int unsigned last;
    int unsigned dn;
    last = 0;
    dn   = d;
    q.delete();
    for (int unsigned ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int unsigned k = 0; k <= dn; k++) q.push_back('{ch[1:0], 1'b0});
        last = ch;
      end
    end
    q.push_back('{last[1:0], 1'b1});
    m_pending = abcd & m;
    m_frame   = '0;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    if (rst) begin
      q.delete();
      m_frame = '0;
    end else if (q.size() == 0) begin
      if (bus.start && bus.mask != 4'b0000) build(bus.mask, bus.dwell);
    end else begin
      e = q.pop_front();
      if (e.valid) begin
`ifdef SCAN_CONT_EN
        if (bus.mask != 4'b0000) build(bus.mask, bus.dwell);
`endif
      end else if (q[0].valid) begin
        m_frame = m_pending;
      end
    end
  end

  always @(posedge clk) begin : compare
    logic [1:0] es;
    logic       eb;
    logic       ev;
    #2;
    if (q.size() == 0) begin
      es = 2'd0; eb = 1'b0; ev = 1'b0;
    end else begin
      es = q[0].sel; eb = 1'b1; ev = q[0].valid;
    end
    check("sel", bus.sel, es);
    check("busy", bus.busy, eb);
    check("frame_valid", bus.frame_valid, ev);
    if (q.size() == 0 || q[0].valid) check("frame", bus.frame, m_frame);
    if (bus.frame_valid) valid_cnt++;
  end

  task automatic start_scan(input logic [3:0] m, input logic [DW-1:0] d);
    @(negedge clk);
    bus.mask  = m;
    bus.dwell = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called right after the start edge; counts edges until frame_valid.
  task automatic wait_valid(input string name, input int exp_edges,
                            input logic [3:0] exp_frame, output logic [3:0] seen);
    int k;
    k    = 0;
    seen = '0;
    while (!bus.frame_valid && k < 200) begin
      if (bus.busy) seen[bus.sel] = 1'b1;
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, exp_edges);
    check({name, "_frame"}, bus.frame, exp_frame);
  endtask

  initial begin : stim
    logic [3:0] seen;
    int         k;
    int         vc;
    bus.start = 1'b0;
    bus.mask  = '0;
    bus.dwell = '0;
    repeat (3) @(negedge clk);
    check("reset_sel", bus.sel, 2'd0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_frame", bus.frame, 4'b0000);
    check("reset_valid", bus.frame_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SCAN_CONT_EN
    abcd = 4'b0001;
    start_scan(4'b0001, 4'd1);
    wait_valid("c0", 2, 4'b0001, seen);
    for (int n = 0; n < 4; n++) begin
      k = 0;
      @(negedge clk);
      k++;
      while (!bus.frame_valid && k < 20) begin
        check("cont_busy", bus.busy, 1'b1);
        @(negedge clk);
        k++;
      end
      check("cont_period", k, 3);
      check("cont_frame", bus.frame, 4'b0001);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cont_rst_busy", bus.busy, 1'b0);
    repeat (4) @(negedge clk);
`else
    // Test 1: all channels, dwell 0.
    abcd = 4'b1101;
    start_scan(4'b1111, 4'd0);
    wait_valid("t1", 4, 4'b1101, seen);
    check("t1_seen", seen, 4'b1111);
    @(negedge clk);
    check("t1_idle_busy", bus.busy, 1'b0);
    check("t1_idle_sel", bus.sel, 2'd0);

    // Test 2: sparse mask, dwell 3.
    abcd = 4'b1010;
    start_scan(4'b1010, 4'd3);
    wait_valid("t2", 8, 4'b1010, seen);
    check("t2_seen", seen, 4'b1010);
    @(negedge clk);
    check("t2_idle_busy", bus.busy, 1'b0);

    // Test 3: empty mask is ignored.
    vc   = valid_cnt;
    abcd = 4'b0101;
    start_scan(4'b0000, 4'd5);
    repeat (5) begin
      check("t3_busy", bus.busy, 1'b0);
      @(negedge clk);
    end
    check("t3_frame", bus.frame, 4'b1010);
    check("t3_no_pulse", valid_cnt, vc);

    // Test 4: restart mid-scan with a different mask is ignored.
    abcd = 4'b0110;
    vc   = valid_cnt;
    @(negedge clk);
    bus.mask  = 4'b1111;
    bus.dwell = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.frame_valid && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 3) begin
        bus.start = 1'b1;
        bus.mask  = 4'b0101;
        bus.dwell = 4'd0;
      end
      if (k == 4) bus.start = 1'b0;
    end
    check("t4_latency", k, 12);
    check("t4_frame", bus.frame, 4'b0110);
    repeat (4) @(negedge clk);
    check("t4_single_pulse", valid_cnt, vc + 1);

    // Test 5: reset while sel==2, then a fresh scan.
    abcd = 4'b1111;
    vc   = valid_cnt;
    start_scan(4'b1111, 4'd3);
    k = 0;
    while (bus.sel != 2'd2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_sel2", bus.sel, 2'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_sel", bus.sel, 2'd0);
    check("t5_rst_busy", bus.busy, 1'b0);
    check("t5_rst_frame", bus.frame, 4'b0000);
    check("t5_rst_valid", bus.frame_valid, 1'b0);
    check("t5_no_pulse", valid_cnt, vc);
    start_scan(4'b0011, 4'd1);
    wait_valid("t5b", 4, 4'b0011, seen);
    check("t5b_seen", seen, 4'b0011);
    repeat (3) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
